// File: rtl/regfile_scoreboard.sv
// MIPS-style register file: 2 async read ports, ALU + load write ports, busy scoreboard
// for outstanding loads. Reads zero latency; writes/marks commit at posedge; no backpressure.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              A_busy,
  output logic              B_busy,
  input  logic              write,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] in,
  input  logic              ld_write,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_in,
  input  logic              mark,
  input  logic [ADDR_W-1:0] mark_rd,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wr_en, ld_en, mark_en;

  assign wr_en   = write    && !(ZR && (rd == '0));
  assign ld_en   = ld_write && !(ZR && (ld_rd == '0));
  assign mark_en = mark     && !(ZR && (mark_rd == '0));

  // Load port is applied last so it wins an address collision with the ALU port.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) regs_d[rd]    = in;
    if (ld_en) regs_d[ld_rd] = ld_in;
  end

  // Set after clear: a new load to the same destination keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (ld_write) busy_d[ld_rd]   = 1'b0;
    if (mark_en)  busy_d[mark_rd] = 1'b1;
    if (ZR)       busy_d[0]       = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];
  logic              rbusy [2];

  assign raddr[0] = rs;
  assign raddr[1] = rt;

  // Read mux priority: zero register, then load bypass, then ALU bypass, then array.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = regs_q[raddr[p]];
      rbusy[p] = busy_q[raddr[p]];
      if (BP && write && (rd == raddr[p])) begin
        rdata[p] = in;
      end
      if (BP && ld_write && (ld_rd == raddr[p])) begin
        rdata[p] = ld_in;
        rbusy[p] = 1'b0;
      end
      if (ZR && (raddr[p] == '0)) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign A      = rdata[0];
  assign B      = rdata[1];
  assign A_busy = rbusy[0];
  assign B_busy = rbusy[1];

endmodule
